// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit for the EX stage. Resolves one bit per
// cycle, holds the pipeline through exe_stall_req, then presents the result for one cycle.
module muldiv_unit #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            op_valid,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            exe_stall_req,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  localparam int HALF = XLEN / 2;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [CNT_W-1:0] LAST_D = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] LAST_W = CNT_W'(HALF - 1);

  function automatic logic [XLEN-1:0] sext_w(input logic [HALF-1:0] v);
    return {{HALF{v[HALF-1]}}, v};
  endfunction

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [3:0]        r_op;
  logic              r_neg;
  logic [2*XLEN-1:0] r_acc;
  logic [2*XLEN-1:0] r_mcand;
  logic [XLEN-1:0]   r_mplier;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_dsor;
  logic [XLEN-1:0]   r_result;

  // Capture-side decode: operand extension, magnitudes, result sign, special cases
  logic [3:0]      w_op;
  logic            w_is_div, w_is_w, w_is_rem, w_a_sgn, w_b_sgn;
  logic            w_a_neg, w_b_neg, w_neg, w_div0, w_ovf;
  logic [XLEN-1:0] w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_min, w_spec;

  always_comb begin
    w_op     = (op inside {4'd9, 4'd10, 4'd11}) ? 4'd0 : op;
    w_is_div = w_op[2];
    w_is_w   = w_op[3];
    w_is_rem = w_is_div & w_op[1];
    w_a_sgn  = w_is_div ? ~w_op[0] : (w_op == 4'd1 || w_op == 4'd2);
    w_b_sgn  = w_is_div ? ~w_op[0] : (w_op == 4'd1);
    if (w_is_w) begin
      w_a_ext = w_a_sgn ? sext_w(src1[HALF-1:0]) : {{HALF{1'b0}}, src1[HALF-1:0]};
      w_b_ext = w_b_sgn ? sext_w(src2[HALF-1:0]) : {{HALF{1'b0}}, src2[HALF-1:0]};
      w_min   = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};
    end else begin
      w_a_ext = src1;
      w_b_ext = src2;
      w_min   = {1'b1, {(XLEN-1){1'b0}}};
    end
    w_a_neg = w_a_sgn & w_a_ext[XLEN-1];
    w_b_neg = w_b_sgn & w_b_ext[XLEN-1];
    w_a_mag = w_a_neg ? -w_a_ext : w_a_ext;
    w_b_mag = w_b_neg ? -w_b_ext : w_b_ext;
    w_neg   = w_is_rem ? w_a_neg : (w_a_neg ^ w_b_neg);
    w_div0  = w_is_div & (w_b_ext == '0);
    w_ovf   = w_is_div & w_a_sgn & (w_a_ext == w_min) & (&w_b_ext);
    if (w_div0) w_spec = w_is_rem ? w_a_ext : '1;
    else        w_spec = w_is_rem ? '0 : w_a_ext;
    if (w_is_w) w_spec = sext_w(w_spec[HALF-1:0]);
  end

  // One iteration step; the final result is formed from the step's next values
  logic [2*XLEN-1:0] w_acc_nxt, w_prod;
  logic [XLEN:0]     w_rem_sh, w_diff;
  logic [XLEN-1:0]   w_rem_nxt, w_quo_nxt, w_q, w_r, w_fin;
  logic              w_ge, w_last;

  always_comb begin
    w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    w_rem_sh  = {r_rem, r_quo[XLEN-1]};
    w_diff    = w_rem_sh - {1'b0, r_dsor};
    w_ge      = ~w_diff[XLEN];
    w_rem_nxt = w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
    w_quo_nxt = {r_quo[XLEN-2:0], w_ge};
    w_prod    = r_neg ? -w_acc_nxt : w_acc_nxt;
    w_q       = r_neg ? -w_quo_nxt : w_quo_nxt;
    w_r       = r_neg ? -w_rem_nxt : w_rem_nxt;
    case (r_op[2:0])
      3'd0:             w_fin = w_prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3: w_fin = w_prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:       w_fin = w_q;
      default:          w_fin = w_r;
    endcase
    if (r_op[3]) w_fin = sext_w(w_fin[HALF-1:0]);
    w_last = (r_cnt == (r_op[3] ? LAST_W : LAST_D));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dsor   <= '0;
      r_result <= '0;
    end else if (flush) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (op_valid) begin
          r_op     <= w_op;
          r_neg    <= w_neg;
          r_cnt    <= '0;
          r_acc    <= '0;
          r_mcand  <= {{XLEN{1'b0}}, w_a_mag};
          r_mplier <= w_b_mag;
          r_rem    <= '0;
          // W dividends sit in the top half so the MSB-first walk ends after HALF steps
          r_quo    <= w_is_w ? {w_a_mag[HALF-1:0], {HALF{1'b0}}} : w_a_mag;
          r_dsor   <= w_b_mag;
          if (w_div0 | w_ovf) begin
            r_state  <= S_DONE;
            r_result <= w_spec;
          end else begin
            r_state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_rem    <= w_rem_nxt;
          r_quo    <= w_quo_nxt;
          if (w_last) begin
            r_state  <= S_DONE;
            r_cnt    <= '0;
            r_result <= w_fin;
          end else begin
            r_cnt    <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state  <= S_IDLE;
          r_result <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign exe_stall_req = ~reset & ~flush &
                         (((r_state == S_IDLE) & op_valid) | (r_state == S_BUSY));
  assign result_valid  = (r_state == S_DONE);
  assign busy          = (r_state != S_IDLE);
  assign result        = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table for results and stall lengths,
// plus hand sequences for flush, async reset and back-to-back issue.
module tb_muldiv_unit;
  localparam int XLEN = 64;
  localparam int NV   = 18;

  logic            clock = 1'b0;
  logic            reset, op_valid, flush;
  logic [3:0]      op;
  logic [XLEN-1:0] src1, src2;
  logic            exe_stall_req, result_valid, busy;
  logic [XLEN-1:0] result;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  muldiv_unit #(.XLEN(XLEN), .CNT_W(7)) dut (
    .clock         (clock),
    .reset         (reset),
    .op_valid      (op_valid),
    .op            (op),
    .src1          (src1),
    .src2          (src2),
    .flush         (flush),
    .exe_stall_req (exe_stall_req),
    .result_valid  (result_valid),
    .result        (result),
    .busy          (busy)
  );

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          stalls;
  } vec_t;

  vec_t vecs[NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h want 0x%h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  // Counts consecutive stall samples, one per cycle, bounded
  task automatic count_stall(output int n);
    n = 0;
    while (exe_stall_req && n < 200) begin
      n++;
      @(negedge clock); #1;
    end
  endtask

  int  n;
  logic seen;

  initial begin
    vecs[0]  = '{4'd0,  64'h0000_0000_0000_0007, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65};
    vecs[1]  = '{4'd3,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    vecs[2]  = '{4'd1,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000, 65};
    vecs[3]  = '{4'd4,  64'hFFFF_FFFF_FFFF_FFEC, 64'h0000_0000_0000_0003, 64'hFFFF_FFFF_FFFF_FFFA, 65};
    vecs[4]  = '{4'd6,  64'hFFFF_FFFF_FFFF_FFEC, 64'h0000_0000_0000_0003, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    vecs[5]  = '{4'd12, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0001, 64'hFFFF_FFFF_8000_0000, 33};
    vecs[6]  = '{4'd5,  64'h0000_0000_0000_007B, 64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[7]  = '{4'd6,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000, 1};
    vecs[8]  = '{4'd2,  64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    vecs[9]  = '{4'd7,  64'h0000_0000_0000_0064, 64'h0000_0000_0000_0007, 64'h0000_0000_0000_0002, 65};
    vecs[10] = '{4'd8,  64'h0000_0001_7FFF_FFFF, 64'h0000_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFFE, 33};
    vecs[11] = '{4'd13, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0000_0000_0000_0010, 64'h0000_0000_0FFF_FFFF, 33};
    vecs[12] = '{4'd14, 64'hFFFF_FFFF_FFFF_FFF9, 64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFF9, 1};
    vecs[13] = '{4'd4,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
    vecs[14] = '{4'd12, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
    vecs[15] = '{4'd9,  64'h0000_0000_0000_0006, 64'h0000_0000_0000_0007, 64'h0000_0000_0000_002A, 65};
    vecs[16] = '{4'd5,  64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0002, 64'h7FFF_FFFF_FFFF_FFFF, 65};
    vecs[17] = '{4'd1,  64'hFFFF_FFFF_FFFF_FFEC, 64'h0000_0000_0000_0003, 64'hFFFF_FFFF_FFFF_FFFF, 65};

    // Reset state, with op_valid high to confirm the stall is held off
    reset = 1'b1; op_valid = 1'b1; flush = 1'b0; op = 4'd0; src1 = 64'd7; src2 = 64'd3;
    repeat (3) @(negedge clock);
    #1;
    chk1("rst_stall", exe_stall_req, 1'b0);
    chk1("rst_valid", result_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_result", result, 64'd0);
    op_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;

    for (int i = 0; i < NV; i++) begin
      op_valid = 1'b1; op = vecs[i].op; src1 = vecs[i].a; src2 = vecs[i].b;
      #1;
      count_stall(n);
      chk($sformatf("vec%0d_stalls", i), 64'(n), 64'(vecs[i].stalls));
      chk1($sformatf("vec%0d_valid", i), result_valid, 1'b1);
      chk($sformatf("vec%0d_result", i), result, vecs[i].exp);
      op_valid = 1'b0;
      @(negedge clock); #1;
      chk1($sformatf("vec%0d_idle", i), busy, 1'b0);
      chk1($sformatf("vec%0d_valid_off", i), result_valid, 1'b0);
    end

    // Flush in the 10th BUSY cycle
    op_valid = 1'b1; op = 4'd4; src1 = 64'hFFFF_FFFF_FFFF_FFEC; src2 = 64'd3;
    #1;
    repeat (10) @(negedge clock);
    #1;
    chk1("flush_pre_busy", busy, 1'b1);
    flush = 1'b1; op_valid = 1'b0;
    #1;
    chk1("flush_stall", exe_stall_req, 1'b0);
    @(negedge clock); #1;
    flush = 1'b0;
    chk1("flush_busy", busy, 1'b0);
    seen = 1'b0;
    repeat (80) begin
      @(negedge clock); #1;
      if (result_valid) seen = 1'b1;
    end
    chk1("flush_no_result", seen, 1'b0);

    // Async reset in BUSY: outputs clear before any clock edge
    op_valid = 1'b1; op = 4'd0; src1 = 64'd7; src2 = 64'hFFFF_FFFF_FFFF_FFFD;
    #1;
    repeat (5) @(negedge clock);
    #2;
    chk1("rstb_pre_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    chk1("rstb_busy", busy, 1'b0);
    chk1("rstb_stall", exe_stall_req, 1'b0);
    chk1("rstb_valid", result_valid, 1'b0);
    chk("rstb_result", result, 64'd0);
    op_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;

    // Async reset in DONE clears the presented result
    op_valid = 1'b1; op = 4'd3; src1 = '1; src2 = '1;
    #1;
    count_stall(n);
    chk("rstd_result_pre", result, 64'hFFFF_FFFF_FFFF_FFFE);
    op_valid = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    chk("rstd_result", result, 64'd0);
    chk1("rstd_valid", result_valid, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    #1;

    // Back-to-back MUL then DIV, op_valid held across DONE
    op_valid = 1'b1; op = 4'd0; src1 = 64'd7; src2 = 64'hFFFF_FFFF_FFFF_FFFD;
    #1;
    count_stall(n);
    chk("b2b_mul_stalls", 64'(n), 64'd65);
    chk1("b2b_mul_valid", result_valid, 1'b1);
    chk("b2b_mul_result", result, 64'hFFFF_FFFF_FFFF_FFEB);
    op = 4'd4; src1 = 64'hFFFF_FFFF_FFFF_FFEC; src2 = 64'd3;
    @(negedge clock); #1;
    chk1("b2b_idle", busy, 1'b0);
    chk1("b2b_capture", exe_stall_req, 1'b1);
    count_stall(n);
    chk("b2b_div_stalls", 64'(n), 64'd65);
    chk1("b2b_div_valid", result_valid, 1'b1);
    chk("b2b_div_result", result, 64'hFFFF_FFFF_FFFF_FFFA);
    op_valid = 1'b0;
    @(negedge clock); #1;
    chk1("b2b_end_idle", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
